axi_lite_csr_slave: RTL and testbench
=====================================

# axi_lite_csr_slave

AXI4-Lite slave control/status register block for the super-resolution accelerator. It terminates the AXI-Lite bus driven by the host/testbench master and exposes a small register map. The map carries start, image size, interrupt enable, busy/done status and a frame counter to the upscaling core. Write and read channels run through independent handshake state machines.

## Interface
- AXI_DATA_WIDTH, 32, data bus width; only 32 is supported.
- AXI_ADDR_WIDTH, 32, address bus width.
- aclk  in  1  clock, all logic rising-edge.
- arstn  in  1  asynchronous active-low reset.
- axi_awvalid/axi_awready  in/out  1  write-address handshake.
- axi_awaddr  in  AXI_ADDR_WIDTH  write address; axi_awprot in 3, ignored.
- axi_wvalid/axi_wready  in/out  1  write-data handshake.
- axi_wdata  in  32  write data; axi_wstrb in 4, byte enables.
- axi_bvalid  out  1  write response valid; axi_bready in 1.
- axi_bresp  out  2  write response: 2'b00 OKAY or 2'b10 SLVERR.
- axi_arvalid/axi_arready  in/out  1  read-address handshake.
- axi_araddr  in  AXI_ADDR_WIDTH  read address; axi_arprot in 3, ignored.
- axi_rvalid  out  1  read data valid; axi_rready in 1.
- axi_rdata  out  32  read data; axi_rresp out 2, response code.
- ctrl_start_o  out  1  one-cycle start pulse to the core.
- ctrl_img_width_o, ctrl_img_height_o  out  16 each  mirror IMG_SIZE fields.
- core_busy_i  in  1  core busy level.
- core_done_i  in  1  one-cycle frame-done pulse.
- irq_o  out  1  level interrupt = DONE & IRQ_EN.

## Operation
- Register map, decoded on addr[3:2]; addr[1:0] ignored. The address is mapped only if addr[AXI_ADDR_WIDTH-1:4]==0.
  - 0x00 CTRL: bit0 START, write-1 pulses ctrl_start_o and reads 0; bit1 IRQ_EN, RW.
  - 0x04 STATUS: bit0 BUSY, RO from core_busy_i; bit1 DONE, sticky, W1C.
  - 0x08 IMG_SIZE: [15:0] width, [31:16] height, RW.
  - 0x0C FRAME_CNT: RO 32-bit count of core_done_i pulses, wraps 0xFFFFFFFF->0.
- Unlisted bits read 0. Writes to RO fields are ignored but still return OKAY.
- Byte strobes: a field byte is written only when its wstrb bit is 1. START and IRQ_EN require wstrb[0].
- Write FSM has two states.
  - W_IDLE: awready=1 until AW is latched; wready=1 until W is latched. AW and W may arrive in either order or in the same cycle. When both are latched, the register update commits and the FSM moves to W_RESP.
  - W_RESP: bvalid=1 and awready=wready=0. On bvalid&bready the latches clear and the FSM returns to W_IDLE.
- Read FSM has two states.
  - R_IDLE: arready=1. On arvalid, rdata/rresp are captured and the FSM moves to R_DATA.
  - R_DATA: rvalid=1 and arready=0. rdata stays stable until rvalid&rready, then the FSM returns to R_IDLE.
- DONE set (core_done_i) and W1C in the same cycle: set wins, DONE stays 1.
- Read and write of the same register committing in the same cycle: the read returns the pre-write value.
- core_done_i while FRAME_CNT is being read: the captured rdata is the pre-increment value.

## Timing
- Reset values:
  - Write path: awready=wready=0, bvalid=0, bresp=0.
  - Read path: arready=0, rvalid=0, rdata=0, rresp=0.
  - Core side: ctrl_start_o=0, width=height=0, irq_o=0.
  - All registers 0. FSMs enter W_IDLE/R_IDLE on the first edge after deassertion.
- Write latency: bvalid rises the cycle after the later of the AW/W handshakes. Register outputs and ctrl_start_o (high exactly 1 cycle) change on that same edge.
- Read latency: rvalid rises the cycle after the AR handshake.
- Maximum throughput is one write per 2 cycles and one read per 2 cycles, each with bready/rready held high.
- Reset asserted mid-transaction aborts it immediately: outputs go to reset values and no partial register update occurs.

## Configuration
- CSR_SLVERR_EN defined: an unmapped address returns SLVERR (2'b10) on bresp/rresp; the write is dropped and rdata=0.
- CSR_SLVERR_EN undefined: an unmapped address returns OKAY; the write is dropped and rdata=0.

## Test plan
- Reset, then read 0x00/0x04/0x08/0x0C -> all rdata=0 and rresp=OKAY. Mid-write arstn pulse -> bvalid=0 and IMG_SIZE stays 0.
- W presented 3 cycles before AW, writing 0x0438_0780 to 0x08 -> bvalid 1 cycle after AW handshake; width=0x0780, height=0x0438.
- Write 0x08 with wstrb=4'b0011 and data 0xFFFF_FFFF after the previous test -> IMG_SIZE=0x0438_FFFF.
- Write 0x3 to 0x00 -> ctrl_start_o high for exactly 1 cycle and IRQ_EN=1. Then core_done_i pulse -> STATUS=0x2, irq_o=1, FRAME_CNT=1.
- W1C 0x2 to 0x04 in the same cycle as core_done_i -> DONE stays 1 and FRAME_CNT=2. Second W1C -> DONE=0, irq_o=0.
- Read 0x40 with rready held low 5 cycles -> rvalid and rdata=0 stable throughout, rresp=SLVERR with CSR_SLVERR_EN and OKAY without.

Source files
------------

// File: rtl/axi_lite_csr_slave.sv
// AXI4-Lite CSR slave for the super-resolution core: CTRL, STATUS, IMG_SIZE, FRAME_CNT.
// Define CSR_SLVERR_EN to answer unmapped addresses with SLVERR instead of OKAY.
module axi_lite_csr_slave #(
    parameter int unsigned AXI_DATA_WIDTH = 32,
    parameter int unsigned AXI_ADDR_WIDTH = 32
) (
    input  logic                        aclk,
    input  logic                        arstn,
    input  logic                        axi_awvalid,
    output logic                        axi_awready,
    input  logic [AXI_ADDR_WIDTH-1:0]   axi_awaddr,
    input  logic [2:0]                  axi_awprot,
    input  logic                        axi_wvalid,
    output logic                        axi_wready,
    input  logic [AXI_DATA_WIDTH-1:0]   axi_wdata,
    input  logic [AXI_DATA_WIDTH/8-1:0] axi_wstrb,
    output logic                        axi_bvalid,
    input  logic                        axi_bready,
    output logic [1:0]                  axi_bresp,
    input  logic                        axi_arvalid,
    output logic                        axi_arready,
    input  logic [AXI_ADDR_WIDTH-1:0]   axi_araddr,
    input  logic [2:0]                  axi_arprot,
    output logic                        axi_rvalid,
    input  logic                        axi_rready,
    output logic [AXI_DATA_WIDTH-1:0]   axi_rdata,
    output logic [1:0]                  axi_rresp,
    output logic                        ctrl_start_o,
    output logic [15:0]                 ctrl_img_width_o,
    output logic [15:0]                 ctrl_img_height_o,
    input  logic                        core_busy_i,
    input  logic                        core_done_i,
    output logic                        irq_o
);
    localparam logic [1:0] RespOkay = 2'b00;
`ifdef CSR_SLVERR_EN
    localparam logic [1:0] RespUnmapped = 2'b10;
`else
    localparam logic [1:0] RespUnmapped = 2'b00;
`endif

    typedef enum logic {WIdle, WResp} w_state_e;
    typedef enum logic {RIdle, RData} r_state_e;

    w_state_e w_state_q, w_state_d;
    r_state_e r_state_q, r_state_d;
    // Holds the ready outputs low until the first edge after reset release.
    logic live_q;

    logic                        aw_done_q, w_done_q;
    logic [AXI_ADDR_WIDTH-1:0]   awaddr_q;
    logic [AXI_DATA_WIDTH-1:0]   wdata_q;
    logic [AXI_DATA_WIDTH/8-1:0] wstrb_q;
    logic [1:0]                  bresp_q, rresp_q;
    logic [AXI_DATA_WIDTH-1:0]   rdata_q, rd_data;

    logic        irq_en_q, done_q, start_q;
    logic [31:0] img_q, cnt_q;

    logic                        aw_hs, w_hs, ar_hs, wr_commit, wr_mapped, rd_mapped, w1c;
    logic [AXI_ADDR_WIDTH-1:0]   wr_addr;
    logic [AXI_DATA_WIDTH-1:0]   wr_data;
    logic [AXI_DATA_WIDTH/8-1:0] wr_strb;

    assign aw_hs     = axi_awvalid & axi_awready;
    assign w_hs      = axi_wvalid & axi_wready;
    assign ar_hs     = axi_arvalid & axi_arready;
    // Commit on the cycle the later of AW/W handshakes, using live bus values if not yet latched.
    assign wr_commit = (w_state_q == WIdle) & (aw_done_q | aw_hs) & (w_done_q | w_hs);
    assign wr_addr   = aw_done_q ? awaddr_q : axi_awaddr;
    assign wr_data   = w_done_q ? wdata_q : axi_wdata;
    assign wr_strb   = w_done_q ? wstrb_q : axi_wstrb;
    assign wr_mapped = (wr_addr[AXI_ADDR_WIDTH-1:4] == '0);
    assign rd_mapped = (axi_araddr[AXI_ADDR_WIDTH-1:4] == '0);
    assign w1c       = wr_commit & wr_mapped & (wr_addr[3:2] == 2'd1) & wr_strb[0] & wr_data[1];

    always_ff @(posedge aclk or negedge arstn) begin
        if (!arstn) begin
            w_state_q <= WIdle;
            r_state_q <= RIdle;
            live_q    <= 1'b0;
        end else begin
            w_state_q <= w_state_d;
            r_state_q <= r_state_d;
            live_q    <= 1'b1;
        end
    end

    always_comb begin
        w_state_d = w_state_q;
        r_state_d = r_state_q;
        unique case (w_state_q)
            WIdle: if (wr_commit) w_state_d = WResp;
            WResp: if (axi_bready) w_state_d = WIdle;
            default: w_state_d = WIdle;
        endcase
        unique case (r_state_q)
            RIdle: if (ar_hs) r_state_d = RData;
            RData: if (axi_rready) r_state_d = RIdle;
            default: r_state_d = RIdle;
        endcase
    end

    always_comb begin
        axi_awready = live_q & (w_state_q == WIdle) & ~aw_done_q;
        axi_wready  = live_q & (w_state_q == WIdle) & ~w_done_q;
        axi_bvalid  = (w_state_q == WResp);
        axi_arready = live_q & (r_state_q == RIdle);
        axi_rvalid  = (r_state_q == RData);
    end

    always_comb begin
        rd_data = '0;
        if (rd_mapped) begin
            case (axi_araddr[3:2])
                2'd0:    rd_data = {30'b0, irq_en_q, 1'b0};
                2'd1:    rd_data = {30'b0, done_q, core_busy_i};
                2'd2:    rd_data = img_q;
                default: rd_data = cnt_q;
            endcase
        end
    end

    always_ff @(posedge aclk or negedge arstn) begin
        if (!arstn) begin
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            bresp_q   <= RespOkay;
            rdata_q   <= '0;
            rresp_q   <= RespOkay;
            irq_en_q  <= 1'b0;
            done_q    <= 1'b0;
            start_q   <= 1'b0;
            img_q     <= '0;
            cnt_q     <= '0;
        end else begin
            if (w_state_q == WResp) begin
                if (axi_bready) begin
                    aw_done_q <= 1'b0;
                    w_done_q  <= 1'b0;
                end
            end else begin
                if (aw_hs) begin
                    aw_done_q <= 1'b1;
                    awaddr_q  <= axi_awaddr;
                end
                if (w_hs) begin
                    w_done_q <= 1'b1;
                    wdata_q  <= axi_wdata;
                    wstrb_q  <= axi_wstrb;
                end
            end
            if (ar_hs) begin
                rdata_q <= rd_data;
                rresp_q <= rd_mapped ? RespOkay : RespUnmapped;
            end
            start_q <= 1'b0;
            if (wr_commit) begin
                bresp_q <= wr_mapped ? RespOkay : RespUnmapped;
                if (wr_mapped) begin
                    case (wr_addr[3:2])
                        2'd0: if (wr_strb[0]) begin
                            irq_en_q <= wr_data[1];
                            start_q  <= wr_data[0];
                        end
                        2'd2: for (int b = 0; b < 4; b++) begin
                            if (wr_strb[b]) img_q[8*b +: 8] <= wr_data[8*b +: 8];
                        end
                        default: ;
                    endcase
                end
            end
            // A done pulse outranks a concurrent W1C.
            done_q <= core_done_i | (done_q & ~w1c);
            cnt_q  <= cnt_q + {31'b0, core_done_i};
        end
    end

    assign axi_bresp         = bresp_q;
    assign axi_rdata         = rdata_q;
    assign axi_rresp         = rresp_q;
    assign ctrl_start_o      = start_q;
    assign ctrl_img_width_o  = img_q[15:0];
    assign ctrl_img_height_o = img_q[31:16];
    assign irq_o             = done_q & irq_en_q;

    logic unused_ok;
    assign unused_ok = ^{axi_awprot, axi_arprot, wr_addr[1:0], axi_araddr[1:0]};
endmodule

// File: tb/tb_axi_lite_csr_slave.sv
// Self-checking bench for axi_lite_csr_slave: directed scenarios plus randomized traffic
// checked against a register-level model of the CSR map.
module tb_axi_lite_csr_slave;
    logic        aclk = 1'b0;
    logic        arstn = 1'b0;
    logic        axi_awvalid = 1'b0, axi_awready;
    logic [31:0] axi_awaddr = '0;
    logic [2:0]  axi_awprot = '0;
    logic        axi_wvalid = 1'b0, axi_wready;
    logic [31:0] axi_wdata = '0;
    logic [3:0]  axi_wstrb = '0;
    logic        axi_bvalid, axi_bready = 1'b0;
    logic [1:0]  axi_bresp;
    logic        axi_arvalid = 1'b0, axi_arready;
    logic [31:0] axi_araddr = '0;
    logic [2:0]  axi_arprot = '0;
    logic        axi_rvalid, axi_rready = 1'b0;
    logic [31:0] axi_rdata;
    logic [1:0]  axi_rresp;
    logic        ctrl_start_o;
    logic [15:0] ctrl_img_width_o, ctrl_img_height_o;
    logic        core_busy_i = 1'b0, core_done_i = 1'b0;
    logic        irq_o;

`ifdef CSR_SLVERR_EN
    localparam logic [1:0] UnmapResp = 2'b10;
`else
    localparam logic [1:0] UnmapResp = 2'b00;
`endif

    axi_lite_csr_slave dut (
        .aclk(aclk), .arstn(arstn),
        .axi_awvalid(axi_awvalid), .axi_awready(axi_awready), .axi_awaddr(axi_awaddr),
        .axi_awprot(axi_awprot), .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
        .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_bvalid(axi_bvalid),
        .axi_bready(axi_bready), .axi_bresp(axi_bresp), .axi_arvalid(axi_arvalid),
        .axi_arready(axi_arready), .axi_araddr(axi_araddr), .axi_arprot(axi_arprot),
        .axi_rvalid(axi_rvalid), .axi_rready(axi_rready), .axi_rdata(axi_rdata),
        .axi_rresp(axi_rresp), .ctrl_start_o(ctrl_start_o),
        .ctrl_img_width_o(ctrl_img_width_o), .ctrl_img_height_o(ctrl_img_height_o),
        .core_busy_i(core_busy_i), .core_done_i(core_done_i), .irq_o(irq_o)
    );

    always #5 aclk = ~aclk;

    int n_checks = 0;
    int n_errors = 0;
    int start_pulses = 0;

    always @(posedge aclk) if (ctrl_start_o === 1'b1) start_pulses++;

    // Reference model: register contents as the host should see them.
    bit          m_irq_en, m_done, m_busy;
    logic [31:0] m_img, m_cnt;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic bit is_mapped(input logic [31:0] a);
        return a[31:4] == 28'h0;
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a);
        if (!is_mapped(a)) return 32'h0;
        case (a[3:2])
            2'd0:    return 32'(m_irq_en) << 1;
            2'd1:    return (32'(m_done) << 1) | 32'(m_busy);
            2'd2:    return m_img;
            default: return m_cnt;
        endcase
    endfunction

    function automatic void model_write(input logic [31:0] a, input logic [31:0] d,
                                        input logic [3:0] s);
        if (!is_mapped(a)) return;
        case (a[3:2])
            2'd0: if (s[0]) m_irq_en = d[1];
            2'd1: if (s[0] && d[1]) m_done = 1'b0;
            2'd2: for (int b = 0; b < 4; b++) if (s[b]) m_img[8*b +: 8] = d[8*b +: 8];
            default: ;
        endcase
    endfunction

    function automatic logic [1:0] exp_resp(input logic [31:0] a);
        return is_mapped(a) ? 2'b00 : UnmapResp;
    endfunction

    task automatic check_core_outs(input string tag);
        check({tag, " width"}, 32'(ctrl_img_width_o), 32'(m_img[15:0]));
        check({tag, " height"}, 32'(ctrl_img_height_o), 32'(m_img[31:16]));
        check({tag, " irq"}, 32'(irq_o), 32'(m_done & m_irq_en));
    endtask

    task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                             input int aw_dly, input int w_dly, input bit done_at_commit);
        bit aw_ok, w_ok, aw_hs, w_hs, exp_start;
        int c;
        aw_ok = 0; w_ok = 0; c = 0;
        exp_start = is_mapped(a) && (a[3:2] == 2'd0) && s[0] && d[0];
        axi_awaddr = a; axi_wdata = d; axi_wstrb = s;
        while (!(aw_ok && w_ok) && c < 40) begin
            axi_awvalid = !aw_ok && c >= aw_dly;
            axi_wvalid  = !w_ok && c >= w_dly;
            #1;
            aw_hs = axi_awvalid && axi_awready;
            w_hs  = axi_wvalid && axi_wready;
            core_done_i = done_at_commit && (aw_ok || aw_hs) && (w_ok || w_hs);
            @(posedge aclk); #1;
            aw_ok = aw_ok || aw_hs;
            w_ok  = w_ok || w_hs;
            core_done_i = 1'b0;
            if (!(aw_ok && w_ok)) check("bvalid before commit", 32'(axi_bvalid), 32'd0);
            c++;
        end
        axi_awvalid = 1'b0;
        axi_wvalid  = 1'b0;
        if (!(aw_ok && w_ok)) begin
            check("write handshake timeout", 32'd0, 32'd1);
            return;
        end
        model_write(a, d, s);
        if (done_at_commit) begin
            m_done = 1'b1;
            m_cnt++;
        end
        check("bvalid latency", 32'(axi_bvalid), 32'd1);
        check("bresp", 32'(axi_bresp), 32'(exp_resp(a)));
        check("start at commit", 32'(ctrl_start_o), 32'(exp_start));
        check_core_outs("after write");
        axi_bready = 1'b1;
        @(posedge aclk); #1;
        axi_bready = 1'b0;
        check("bvalid clear", 32'(axi_bvalid), 32'd0);
        check("start one cycle", 32'(ctrl_start_o), 32'd0);
    endtask

    task automatic axi_read(input logic [31:0] a, input int hold,
                            output logic [31:0] d, output logic [1:0] r);
        int c;
        c = 0;
        d = '0; r = '0;
        axi_araddr  = a;
        axi_arvalid = 1'b1;
        #1;
        while (!axi_arready && c < 40) begin
            @(posedge aclk); #1;
            c++;
        end
        if (!axi_arready) begin
            axi_arvalid = 1'b0;
            check("arready timeout", 32'd0, 32'd1);
            return;
        end
        @(posedge aclk); #1;
        axi_arvalid = 1'b0;
        check("rvalid latency", 32'(axi_rvalid), 32'd1);
        d = axi_rdata;
        r = axi_rresp;
        for (int i = 0; i < hold; i++) begin
            @(posedge aclk); #1;
            check("rvalid held", 32'(axi_rvalid), 32'd1);
            check("rdata stable", axi_rdata, d);
        end
        axi_rready = 1'b1;
        @(posedge aclk); #1;
        axi_rready = 1'b0;
        check("rvalid clear", 32'(axi_rvalid), 32'd0);
    endtask

    task automatic read_expect(input string tag, input logic [31:0] a, input int hold);
        logic [31:0] d;
        logic [1:0]  r;
        logic [31:0] exp_d;
        exp_d = model_read(a);
        axi_read(a, hold, d, r);
        check(tag, d, exp_d);
        check({tag, " rresp"}, 32'(r), 32'(exp_resp(a)));
    endtask

    task automatic pulse_done();
        core_done_i = 1'b1;
        @(posedge aclk); #1;
        core_done_i = 1'b0;
        m_done = 1'b1;
        m_cnt++;
    endtask

    task automatic apply_reset();
        arstn = 1'b0;
        axi_awvalid = 0; axi_wvalid = 0; axi_bready = 0; axi_arvalid = 0; axi_rready = 0;
        core_done_i = 0;
        m_irq_en = 0; m_done = 0; m_img = '0; m_cnt = '0;
        #1;
        check("reset handshake outs",
              32'({axi_awready, axi_wready, axi_bvalid, axi_bresp,
                   axi_arready, axi_rvalid, axi_rresp}), 32'd0);
        check("reset rdata", axi_rdata, 32'd0);
        check("reset core outs",
              32'({ctrl_start_o, ctrl_img_width_o, ctrl_img_height_o, irq_o}), 32'd0);
        @(posedge aclk); #1;
        arstn = 1'b1;
        #1;
        check("ready low before first edge", 32'({axi_awready, axi_arready}), 32'd0);
        @(posedge aclk); #1;
        check("ready after first edge", 32'({axi_awready, axi_wready, axi_arready}), 32'h7);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a, d, rd0;
        logic [1:0]  r0;
        int          op, base;

        m_busy = 0;
        @(posedge aclk); #1;
        apply_reset();
        for (int i = 0; i < 4; i++) read_expect("reset read", 32'(i * 4), 0);

        // AW accepted, then reset before W: nothing may land in IMG_SIZE.
        axi_awaddr = 32'h8; axi_awvalid = 1'b1;
        @(posedge aclk); #1;
        axi_awvalid = 1'b0;
        arstn = 1'b0;
        #1;
        check("mid-write reset bvalid", 32'(axi_bvalid), 32'd0);
        @(posedge aclk); #1;
        arstn = 1'b1;
        @(posedge aclk); #1;
        read_expect("img after aborted write", 32'h8, 0);

        axi_write(32'h8, 32'h0438_0780, 4'hF, 3, 0, 0);
        check("width 0x780", 32'(ctrl_img_width_o), 32'h780);
        check("height 0x438", 32'(ctrl_img_height_o), 32'h438);
        axi_write(32'h8, 32'hFFFF_FFFF, 4'b0011, 0, 0, 0);
        read_expect("img partial strobe", 32'h8, 0);
        check("img partial literal", m_img, 32'h0438_FFFF);

        base = start_pulses;
        axi_write(32'h0, 32'h3, 4'hF, 0, 1, 0);
        @(posedge aclk); #1;
        check("start pulse count", 32'(start_pulses - base), 32'd1);
        read_expect("ctrl readback", 32'h0, 0);
        pulse_done();
        check("irq after done", 32'(irq_o), 32'd1);
        read_expect("status done", 32'h4, 0);
        read_expect("frame cnt 1", 32'hC, 0);

        axi_write(32'h4, 32'h2, 4'hF, 0, 0, 1);
        read_expect("status set wins", 32'h4, 0);
        read_expect("frame cnt 2", 32'hC, 0);
        axi_write(32'h4, 32'h2, 4'hF, 0, 0, 0);
        check("irq cleared", 32'(irq_o), 32'd0);
        read_expect("status cleared", 32'h4, 0);

        read_expect("unmapped read", 32'h40, 5);
        axi_write(32'h40, 32'hFFFF_FFFF, 4'hF, 0, 0, 0);

        // Read and write of IMG_SIZE committing on the same edge.
        a = model_read(32'h8);
        fork
            axi_write(32'h8, 32'h1234_5678, 4'hF, 0, 0, 0);
            axi_read(32'h8, 0, rd0, r0);
        join
        check("read sees pre-write", rd0, a);

        for (int i = 0; i < 150; i++) begin
            op = $urandom_range(0, 9);
            if ($urandom_range(0, 4) < 4) a = {28'h0, 2'($urandom_range(0, 3)), 2'($urandom)};
            else begin
                a = $urandom;
                if (a[31:4] == 28'h0) a[31] = 1'b1;
            end
            if (op < 4) begin
                d = $urandom;
                axi_write(a, d, 4'($urandom), $urandom_range(0, 3), $urandom_range(0, 3),
                          $urandom_range(0, 7) == 0);
            end else if (op < 8) begin
                read_expect("random read", a, $urandom_range(0, 2));
            end else if (op == 8) begin
                pulse_done();
                check_core_outs("after done");
            end else begin
                m_busy = 1'($urandom);
                core_busy_i = m_busy;
                @(posedge aclk); #1;
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
